// File: rtl/hcsr04_ranger.sv
// HC-SR04 measurement sequencer: periodic trigger, echo pulse timing and
// divider-free centimetre conversion, published as distance plus a valid strobe.
module hcsr04_ranger #(
    parameter int TRIG_CYCLES    = 120,
    parameter int CM_CYCLES      = 696,
    parameter int TIMEOUT_CYCLES = 360000,
    parameter int PERIOD_CYCLES  = 720000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic [15:0] distance,
    output logic        valid,
    output logic        timeout,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

    localparam logic [19:0] TRIG_LAST    = 20'(TRIG_CYCLES - 1);
    localparam logic [19:0] CM_LAST      = 20'(CM_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [19:0] PERIOD_LAST  = 20'(PERIOD_CYCLES - 1);
    localparam logic [15:0] CM_MAX       = 16'hFFFE;

    state_t      state;
    logic [19:0] period_cnt;
    logic [19:0] timeout_cnt;
    logic [19:0] prescale;
    logic [15:0] cm_cnt;
    logic [15:0] cm_inc;
    logic        echo_m;
    logic        echo_s;
    logic        echo_d;
    logic        echo_rise;
    logic        echo_fall;
    logic        cm_wrap;

    // echo is asynchronous: two flops to synchronize, a third for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_d;
    assign echo_fall = ~echo_s & echo_d;
    assign cm_wrap   = (prescale == CM_LAST);
    assign cm_inc    = (cm_cnt == CM_MAX) ? cm_cnt : cm_cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            period_cnt  <= '0;
            timeout_cnt <= '0;
            prescale    <= '0;
            cm_cnt      <= '0;
            trig        <= 1'b0;
            distance    <= '0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= TRIG;
                        trig       <= 1'b1;
                        busy       <= 1'b1;
                        period_cnt <= '0;
                    end
                end
                TRIG: begin
                    period_cnt <= period_cnt + 20'd1;
                    if (period_cnt == TRIG_LAST) begin
                        state       <= WAIT_RISE;
                        trig        <= 1'b0;
                        timeout_cnt <= '0;
                    end
                end
                WAIT_RISE: begin
                    period_cnt  <= period_cnt + 20'd1;
                    timeout_cnt <= timeout_cnt + 20'd1;
                    if (timeout_cnt == TIMEOUT_LAST) begin
                        state    <= HOLDOFF;
                        distance <= 16'hFFFF;
                        timeout  <= 1'b1;
                        valid    <= 1'b1;
                    end else if (echo_rise) begin
                        state    <= MEASURE;
                        prescale <= '0;
                        cm_cnt   <= '0;
                    end
                end
                MEASURE: begin
                    period_cnt  <= period_cnt + 20'd1;
                    timeout_cnt <= timeout_cnt + 20'd1;
                    // the fall cycle still counts as a high clock, so fold in a pending wrap
                    if (echo_fall) begin
                        state    <= HOLDOFF;
                        distance <= cm_wrap ? cm_inc : cm_cnt;
                        timeout  <= 1'b0;
                        valid    <= 1'b1;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state    <= HOLDOFF;
                        distance <= 16'hFFFF;
                        timeout  <= 1'b1;
                        valid    <= 1'b1;
                    end else if (cm_wrap) begin
                        prescale <= '0;
                        cm_cnt   <= cm_inc;
                    end else begin
                        prescale <= prescale + 20'd1;
                    end
                end
                HOLDOFF: begin
                    if (period_cnt == PERIOD_LAST) begin
                        period_cnt <= '0;
                        if (enable) begin
                            state <= TRIG;
                            trig  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        period_cnt <= period_cnt + 20'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    trig  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hcsr04_ranger.sv
// Self-checking bench for hcsr04_ranger: scenario tasks compared against an
// arithmetic model of trigger timing, echo length and timeout rules.
module tb_hcsr04_ranger;
    localparam int TRIG = 4;
    localparam int CM   = 10;
    localparam int TMO  = 500;
    localparam int PER  = 1000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        echo;
    logic        trig;
    logic [15:0] distance;
    logic        valid;
    logic        timeout;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          s_next = 0;
    logic [15:0] model_dist = 16'd0;
    logic        model_to = 1'b0;

    hcsr04_ranger #(
        .TRIG_CYCLES   (TRIG),
        .CM_CYCLES     (CM),
        .TIMEOUT_CYCLES(TMO),
        .PERIOD_CYCLES (PER)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .echo    (echo),
        .trig    (trig),
        .distance(distance),
        .valid   (valid),
        .timeout (timeout),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full trigger period starting at edge s (trig just went high).
    // Echo is driven so raw echo is sampled high by edges rise_edge..fall_edge-1.
    task automatic measure(input string name, input int s, input int rise_edge,
                           input int fall_edge, input int drop_at);
        int          tmo_at;
        int          exp_at;
        int          vcount;
        int          vat;
        int          trig_err;
        int          busy_err;
        int          hold_err;
        logic [15:0] exp_d;
        logic [15:0] vd;
        logic        exp_to;
        logic        vto;
        logic        en_final;
        logic        exp_trig;
        logic        exp_busy;
        bit          rise_seen;

        en_final  = (drop_at == 0);
        tmo_at    = s + TRIG + TMO;
        rise_seen = (rise_edge > s + TRIG) && (rise_edge < fall_edge);
        if (rise_seen && (fall_edge + 2 <= tmo_at)) begin
            exp_at = fall_edge + 2;
            exp_d  = 16'((fall_edge - rise_edge) / CM);
            exp_to = 1'b0;
        end else begin
            exp_at = tmo_at;
            exp_d  = 16'hFFFF;
            exp_to = 1'b1;
        end
        vcount = 0; vat = -1; vd = 16'd0; vto = 1'b0;
        trig_err = 0; busy_err = 0; hold_err = 0;

        echo = (s + 1 >= rise_edge) && (s + 1 < fall_edge);
        for (int k = 1; k <= PER; k++) begin
            step(1);
            exp_trig = (k < TRIG) || (k == PER && en_final);
            exp_busy = (k < PER) || en_final;
            if (trig !== exp_trig) trig_err++;
            if (busy !== exp_busy) busy_err++;
            if (valid === 1'b1) begin
                vcount++;
                vat = s + k;
                vd  = distance;
                vto = timeout;
            end
            if (s + k == exp_at) begin
                model_dist = exp_d;
                model_to   = exp_to;
            end
            if (distance !== model_dist || timeout !== model_to) hold_err++;
            if (drop_at != 0 && s + k == drop_at) enable = 1'b0;
            echo = (s + k + 1 >= rise_edge) && (s + k + 1 < fall_edge);
        end

        checks++;
        if (vcount !== 1) begin
            errors++;
            $display("[TB] FAIL %s valid_count: got %0d want 1", name, vcount);
        end
        checks++;
        if (vat !== exp_at) begin
            errors++;
            $display("[TB] FAIL %s valid_time: got %0d want %0d (trigger at %0d)", name, vat - s, exp_at - s, 0);
        end
        checks++;
        if (vd !== exp_d) begin
            errors++;
            $display("[TB] FAIL %s distance: got %0d want %0d", name, vd, exp_d);
        end
        checks++;
        if (vto !== exp_to) begin
            errors++;
            $display("[TB] FAIL %s timeout: got %0b want %0b", name, vto, exp_to);
        end
        checks++;
        if (trig_err !== 0) begin
            errors++;
            $display("[TB] FAIL %s trig_shape: got %0d bad cycles want 0", name, trig_err);
        end
        checks++;
        if (busy_err !== 0) begin
            errors++;
            $display("[TB] FAIL %s busy: got %0d bad cycles want 0", name, busy_err);
        end
        checks++;
        if (hold_err !== 0) begin
            errors++;
            $display("[TB] FAIL %s result_hold: got %0d bad cycles want 0", name, hold_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; echo = 1'b0;
        #2 rst = 1'b1;
        step(3);
        checks++; if (trig !== 1'b0) begin errors++; $display("[TB] FAIL reset_trig: got %0b want 0", trig); end
        checks++; if (distance !== 16'd0) begin errors++; $display("[TB] FAIL reset_distance: got %0d want 0", distance); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %0b want 0", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b0;
        model_dist = 16'd0;
        model_to   = 1'b0;
        step(4);
        checks++; if (trig !== 1'b0) begin errors++; $display("[TB] FAIL idle_trig: got %0b want 0", trig); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_first_trigger();
        enable = 1'b1;
        step(1);
        checks++; if (trig !== 1'b1) begin errors++; $display("[TB] FAIL first_trig_start: got %0b want 1", trig); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL first_busy: got %0b want 1", busy); end
        s_next = 0;
    endtask

    task automatic test_nominal();
        measure("nominal", s_next, s_next + 20, s_next + 20 + 237, 0);
        s_next += PER;
    endtask

    task automatic test_no_echo();
        measure("no_echo", s_next, 0, 0, 0);
        s_next += PER;
    endtask

    task automatic test_fall_timeout_tie();
        measure("tie", s_next, s_next + 30, s_next + TRIG + TMO - 2, 0);
        s_next += PER;
        measure("past_tie", s_next, s_next + 30, s_next + TRIG + TMO - 1, 0);
        s_next += PER;
    endtask

    task automatic test_random();
        int r;
        int len;
        for (int i = 0; i < 6; i++) begin
            r   = int'($urandom_range(60, 6));
            len = int'($urandom_range(500, 1));
            measure("random", s_next, s_next + TRIG + r, s_next + TRIG + r + len, 0);
            s_next += PER;
        end
    endtask

    task automatic test_enable_drop();
        int bad;
        measure("enable_drop", s_next, s_next + 40, s_next + 40 + 123, s_next + 60);
        bad = 0;
        for (int k = 0; k < 1200; k++) begin
            step(1);
            if (trig !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL enable_drop_idle: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_stuck_high();
        echo = 1'b1;
        step(5);
        enable = 1'b1;
        step(1);
        checks++; if (trig !== 1'b1) begin errors++; $display("[TB] FAIL stuck_trig_start: got %0b want 1", trig); end
        s_next = 0;
        measure("stuck_high", s_next, s_next - 6, s_next + PER + 3, 0);
        s_next += PER;
        echo = 1'b0;
    endtask

    task automatic test_reset_mid_trig();
        step(1);
        checks++; if (trig !== 1'b1) begin errors++; $display("[TB] FAIL trig_second_clock: got %0b want 1", trig); end
        rst = 1'b1;
        #1;
        checks++; if (trig !== 1'b0) begin errors++; $display("[TB] FAIL async_trig_drop: got %0b want 0", trig); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_busy_drop: got %0b want 0", busy); end
        step(2);
        checks++; if (distance !== 16'd0) begin errors++; $display("[TB] FAIL reset_clears_distance: got %0d want 0", distance); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_clears_timeout: got %0b want 0", timeout); end
        rst = 1'b0;
        model_dist = 16'd0;
        model_to   = 1'b0;
        step(1);
        checks++; if (trig !== 1'b1) begin errors++; $display("[TB] FAIL retrigger_start: got %0b want 1", trig); end
        s_next = 0;
        measure("after_reset", s_next, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_first_trigger();
        test_nominal();
        test_no_echo();
        test_fall_timeout_tie();
        test_random();
        test_enable_drop();
        test_stuck_high();
        test_reset_mid_trig();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
